// File: rtl/core_if.sv
// core_if: fetch/data bus between the core datapath and its unified memory
interface core_if;
  logic [15:0] iaddr;
  logic [15:0] daddr;
  logic [31:0] idata;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        we;
  modport master (output iaddr, daddr, wdata, be, we, input idata, rdata);
  modport slave (input iaddr, daddr, wdata, be, we, output idata, rdata);
endinterface

// File: rtl/core.sv
// core: single-cycle RV32I + Zicsr + M-mode traps with unified 256 KiB memory; CORE_TRACE_EN enables a retire trace
module core_mem (
  input logic   clk,
  core_if.slave bus
);
  logic [31:0] m [0:65535];
  assign bus.idata = m[bus.iaddr];
  assign bus.rdata = m[bus.daddr];
  // merge enabled byte lanes into the addressed word; memory is never reset
  always_ff @(posedge clk)
    if (bus.we)
      m[bus.daddr] <= {bus.be[3] ? bus.wdata[31:24] : bus.rdata[31:24],
                       bus.be[2] ? bus.wdata[23:16] : bus.rdata[23:16],
                       bus.be[1] ? bus.wdata[15:8]  : bus.rdata[15:8],
                       bus.be[0] ? bus.wdata[7:0]   : bus.rdata[7:0]};
endmodule

module core (
  input logic clk,
  input logic rst
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13;
  localparam logic [6:0] OP_OP = 7'h33, OP_FENCE = 7'h0f, OP_SYS = 7'h73;
  logic [31:0] pc;
  logic [31:0] rs [0:31];
  logic [31:0] csr [0:4095];
  logic [31:0] inst, a, b, y, alu, ld, wv, npc, old, src, cnew, cause, word;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [17:0] addr;
  logic [15:0] half;
  logic [11:0] ca;
  logic [7:0]  byte_v;
  logic [6:0]  op;
  logic [4:0]  rd, r1, r2;
  logic [2:0]  f3;
  logic        take, is_csr, is_ecall, is_mret, illegal, trap, wr;
  core_if bus ();
  core_mem memory (.clk(clk), .bus(bus));
  assign inst  = bus.idata;
  assign op    = inst[6:0];
  assign rd    = inst[11:7];
  assign f3    = inst[14:12];
  assign r1    = inst[19:15];
  assign r2    = inst[24:20];
  assign ca    = inst[31:20];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign a     = rs[r1];
  assign b     = rs[r2];
  assign y     = op == OP_OP ? b : imm_i;
  // ALU: the same funct3 decode serves OP and OP-IMM; bit 30 selects SUB/SRA
  always_comb
    case (f3)
      3'd0:    alu = (op == OP_OP && inst[30]) ? a - y : a + y;
      3'd1:    alu = a << y[4:0];
      3'd2:    alu = {31'b0, $signed(a) < $signed(y)};
      3'd3:    alu = {31'b0, a < y};
      3'd4:    alu = a ^ y;
      3'd5:    alu = inst[30] ? $unsigned($signed(a) >>> y[4:0]) : a >> y[4:0];
      3'd6:    alu = a | y;
      default: alu = a & y;
    endcase
  assign take   = (f3[2] ? (f3[1] ? a < b : $signed(a) < $signed(b)) : a == b) ^ f3[0];
  assign addr   = 18'(op == OP_ST ? a + imm_s : a + imm_i);
  assign word   = bus.rdata;
  assign byte_v = addr[1] ? (addr[0] ? word[31:24] : word[23:16]) : (addr[0] ? word[15:8] : word[7:0]);
  assign half   = addr[1] ? word[31:16] : word[15:0];
  assign ld     = f3[1] ? word : f3[0] ? {{16{~f3[2] & half[15]}}, half} : {{24{~f3[2] & byte_v[7]}}, byte_v};
  assign bus.iaddr = pc[17:2];
  assign bus.daddr = addr[17:2];
  assign bus.wdata = f3[1] ? b : f3[0] ? {2{b[15:0]}} : {4{b[7:0]}};
  assign bus.be    = f3[1] ? 4'hf : f3[0] ? (addr[1] ? 4'hc : 4'h3) : 4'b0001 << addr[1:0];
  // gating with rst keeps a store from landing on an edge where reset is held
  assign bus.we    = op == OP_ST && !rst;
  assign old      = csr[ca];
  assign src      = f3[2] ? {27'b0, r1} : a;
  assign cnew     = f3[1:0] == 2'b01 ? src : f3[1:0] == 2'b10 ? old | src : old & ~src;
  assign is_ecall = inst == 32'h0000_0073;
  assign is_mret  = inst == 32'h3020_0073;
  assign is_csr   = op == OP_SYS && f3[1:0] != 2'b00;
  assign illegal  = !(op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_OP, OP_FENCE, OP_SYS}) ||
                    (op == OP_SYS && f3[1:0] == 2'b00 && !is_ecall && !is_mret);
  assign trap     = illegal || is_ecall;
  assign cause    = illegal ? 32'd2 : 32'd11;
  assign wr       = rd != 5'd0 && !trap && !(op inside {OP_BR, OP_ST, OP_FENCE});
  assign wv       = op == OP_LUI ? imm_u : op == OP_AUIPC ? pc + imm_u :
                    (op == OP_JAL || op == OP_JALR) ? pc + 32'd4 : op == OP_LD ? ld : op == OP_SYS ? old : alu;
  assign npc      = trap ? {csr[12'h305][31:2], 2'b00} : is_mret ? csr[12'h341] :
                    op == OP_JAL ? pc + imm_j : op == OP_JALR ? (a + imm_i) & ~32'd1 :
                    (op == OP_BR && take) ? pc + imm_b : pc + 32'd4;
  // program counter
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= '0;
    else pc <= npc;
  genvar g;
  for (g = 0; g < 32; g++) begin : x
    // one register per entry; rd = x0 never asserts wr, so rs[0] stays zero
    always_ff @(posedge clk or posedge rst)
      if (rst) rs[g] <= '0;
      else if (wr && rd == 5'(g)) rs[g] <= wv;
  end
  for (g = 0; g < 4096; g++) begin : c
    // traps own mepc/mcause/mtval on their cycle; otherwise a CSR instruction writes its target
    always_ff @(posedge clk or posedge rst)
      if (rst) csr[g] <= '0;
      else if (trap ? (g == 'h341 || g == 'h342 || (g == 'h343 && illegal)) : (is_csr && ca == 12'(g)))
        csr[g] <= trap ? (g == 'h341 ? pc : g == 'h342 ? cause : inst) : cnew;
  end
`ifdef CORE_TRACE_EN
  // retire trace
  always_ff @(posedge clk)
    if (!rst) $display("pc=%08h inst=%08h rd=x%0d val=%08h we=%0d", pc, inst, rd, wv, wr);
`else
`endif
endmodule

// File: tb/tb_core.sv
// tb_core: directed programs for core with a cycle-keyed scoreboard of architectural state
module tb_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n = 0;
  int checks = 0;
  int errors = 0;
  typedef struct { int cyc; int kind; int idx; logic [31:0] exp; string name; } chk_t;
  chk_t q[$];

  core dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) n <= 0;
    else n <= n + 1;

  function automatic logic [31:0] peek(int k, int i);
    case (k)
      0:       return dut.pc;
      1:       return dut.rs[i];
      2:       return dut.csr[i];
      default: return dut.memory.m[i];
    endcase
  endfunction

  always @(negedge clk) begin
    chk_t e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].cyc == n) begin
      e = q.pop_front();
      act = peek(e.kind, e.idx);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %08h expected %08h (cycle %0d)", e.name, act, e.exp, n);
      end
    end
  end

  task automatic push(input int cyc, input int kind, input int idx, input logic [31:0] exp, input string name);
    q.push_back('{cyc, kind, idx, exp, name});
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() > 0; k++) @(negedge clk);
    #1;
    foreach (q[i]) $display("FAIL %s: never reached cycle %0d", q[i].name, q[i].cyc);
    checks += q.size();
    errors += q.size();
    q.delete();
  endtask

  initial begin
    logic [31:0] p1 [0:8];
    logic [31:0] p2 [0:18];
    bit found;
    p1 = '{32'hFFF00093, 32'h201000A3, 32'h20400103, 32'h20404183, 32'h00500013,
           32'h10000213, 32'h305212F3, 32'h00308333, 32'h00000073};
    p2 = '{32'h123450B7, 32'h67808093, 32'h20102423, 32'h201005A3, 32'h20802103,
           32'h20A01183, 32'h40100233, 32'h40425293, 32'h00122333, 32'h001233B3,
           32'h00124463, 32'h00100413, 32'h008004EF, 32'h00000013, 32'h01148567,
           32'h00000000, 32'h00000000, 32'h00001597, 32'hFFFFFFFF};
    for (int i = 0; i < 65536; i++) dut.memory.m[i] = '0;
    for (int i = 0; i < 9; i++) dut.memory.m[i] = p1[i];
    dut.memory.m[16'h40] = 32'h30200073;
    dut.memory.m[16'h81] = 32'h00000080;
    push(0, 0, 0, 32'h0, "rst_pc");
    push(0, 1, 1, 32'h0, "rst_x1");
    push(0, 2, 'h305, 32'h0, "rst_mtvec");
    drain();
    push(1, 0, 0, 32'h4, "pc_after_addi");
    push(1, 1, 1, 32'hFFFFFFFF, "addi_neg");
    push(2, 3, 'h80, 32'h0000FF00, "sb_lane1");
    push(3, 1, 2, 32'hFFFFFF80, "lb_sext");
    push(4, 1, 3, 32'h00000080, "lbu_zext");
    push(5, 1, 0, 32'h0, "x0_stays_zero");
    push(6, 1, 4, 32'h100, "addi_mtvec_val");
    push(7, 2, 'h305, 32'h100, "csrrw_mtvec");
    push(7, 1, 5, 32'h0, "csrrw_old");
    push(8, 1, 6, 32'h7F, "add");
    push(8, 0, 0, 32'h20, "pc_at_ecall");
    push(9, 0, 0, 32'h100, "ecall_pc");
    push(9, 2, 'h341, 32'h20, "ecall_mepc");
    push(9, 2, 'h342, 32'd11, "ecall_mcause");
    push(10, 0, 0, 32'h20, "mret_pc");
    @(negedge clk) rst = 1'b0;
    drain();
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 19; i++) dut.memory.m[i] = p2[i];
    push(1, 1, 1, 32'h12345000, "lui");
    push(2, 1, 1, 32'h12345678, "addi_pos");
    push(3, 3, 'h82, 32'h12345678, "sw");
    push(4, 3, 'h82, 32'h78345678, "sb_lane3");
    push(5, 1, 2, 32'h78345678, "lw_after_store");
    push(6, 1, 3, 32'h00007834, "lh_upper");
    push(7, 1, 4, 32'hEDCBA988, "sub");
    push(8, 1, 5, 32'hFEDCBA98, "srai");
    push(9, 1, 6, 32'h1, "slt");
    push(10, 1, 7, 32'h0, "sltu");
    push(10, 0, 0, 32'h28, "pc_at_blt");
    @(negedge clk) rst = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (dut.pc == 32'h30) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_0x30: got pc %08h expected 00000030", dut.pc);
    end
    rst = 1'b1;
    push(0, 0, 0, 32'h0, "midrst_pc");
    push(0, 1, 1, 32'h0, "midrst_x1");
    push(0, 1, 5, 32'h0, "midrst_x5");
    push(0, 3, 'h82, 32'h78345678, "midrst_mem82");
    push(0, 3, 'h80, 32'h0000FF00, "midrst_mem80");
    drain();
    push(2, 1, 1, 32'h12345678, "rerun_x1");
    push(11, 0, 0, 32'h30, "blt_taken");
    push(11, 1, 8, 32'h0, "skipped_addi");
    push(12, 0, 0, 32'h38, "jal_pc");
    push(12, 1, 9, 32'h34, "jal_link");
    push(13, 0, 0, 32'h44, "jalr_bit0");
    push(13, 1, 10, 32'h3C, "jalr_link");
    push(14, 1, 11, 32'h1044, "auipc");
    push(15, 0, 0, 32'h0, "illegal_pc");
    push(15, 2, 'h341, 32'h48, "illegal_mepc");
    push(15, 2, 'h342, 32'd2, "illegal_mcause");
    push(15, 2, 'h343, 32'hFFFFFFFF, "illegal_mtval");
    @(negedge clk) rst = 1'b0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
